// File: rtl/axis_crc32_mpeg2_pkg_prm.sv
// Shared parameters and CRC helper for the CRC32/MPEG-2 stream blocks.
package axis_crc32_mpeg2_pkg_prm;

  localparam logic [31:0] INIT_CRC      = 32'hFFFF_FFFF;
  localparam logic [31:0] POLY_CRC      = 32'h04C1_1DB7;
  localparam int          CHK_CNT_WIDTH = 16;

  // One 32-bit word folded into the CRC: load c^d, then 32 MSB-first
  // shift/XOR iterations (no reflection, no final XOR).
  function automatic logic [31:0] crc32_step(input logic [31:0] c,
                                             input logic [31:0] d,
                                             input logic [31:0] poly);
    logic [31:0] r;
    r = c ^ d;
    for (int i = 0; i < 32; i++) begin
      if (r[31]) begin
        r = {r[30:0], 1'b0} ^ poly;
      end else begin
        r = {r[30:0], 1'b0};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_mpeg2_step.sv
// Combinational CRC32/MPEG-2 word step, shared by generator and checker.
module crc32_mpeg2_step
  import axis_crc32_mpeg2_pkg_prm::*;
#(
  parameter logic [31:0] POLY = POLY_CRC
) (
  input  logic [31:0] crc_in,
  input  logic [31:0] data_in,
  output logic [31:0] crc_out
);

  // Fold one data word into the running CRC within a single cycle.
  always_comb begin
    crc_out = crc32_step(crc_in, data_in, POLY);
  end

endmodule

// File: rtl/axis_crc32_mpeg2_check.sv
// AXI-Stream CRC32/MPEG-2 checker: strips the trailing CRC word, moves
// tlast onto the last payload word and reports pass/fail per frame.
module axis_crc32_mpeg2_check
  import axis_crc32_mpeg2_pkg_prm::*;
#(
  parameter logic [31:0] INIT_CRC_P = INIT_CRC,
  parameter logic [31:0] POLY_CRC_P = POLY_CRC,
  parameter int          CNT_WIDTH  = CHK_CNT_WIDTH
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [31:0]          s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  output logic [31:0]          m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic                 crc_done,
  output logic                 crc_ok,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [31:0] crc_r;
  logic [31:0] crc_next_s;
  logic [31:0] hold_data_r;
  logic        hold_valid_r;
  logic        accept_s;
  logic        load_out_s;
  logic        frame_end_s;
  logic        frame_bad_s;

  crc32_mpeg2_step #(
    .POLY (POLY_CRC_P)
  ) u_step (
    .crc_in  (crc_r),
    .data_in (s_axis_tdata),
    .crc_out (crc_next_s)
  );

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;

  // Decode the handshake into load/end-of-frame strobes.
  always_comb begin
    accept_s    = s_axis_tvalid && s_axis_tready;
    load_out_s  = accept_s && hold_valid_r;
    frame_end_s = accept_s && s_axis_tlast;
    if (frame_end_s) begin
      frame_bad_s = (crc_r != s_axis_tdata);
    end else begin
      frame_bad_s = 1'b0;
    end
  end

  // Running CRC and one-word hold stage; a word waits here until the next
  // beat reveals whether it is the last payload word.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      crc_r        <= INIT_CRC_P;
      hold_data_r  <= 32'h0000_0000;
      hold_valid_r <= 1'b0;
    end else if (accept_s) begin
      if (s_axis_tlast) begin
        crc_r        <= INIT_CRC_P;
        hold_valid_r <= 1'b0;
      end else begin
        crc_r        <= crc_next_s;
        hold_data_r  <= s_axis_tdata;
        hold_valid_r <= 1'b1;
      end
    end
  end

  // Output register: loaded from the hold stage, emptied by downstream ready.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis_tdata  <= 32'h0000_0000;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else if (load_out_s) begin
      m_axis_tdata  <= hold_data_r;
      m_axis_tlast  <= s_axis_tlast;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Per-frame status pulse and saturating frame/error counters.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      crc_done  <= 1'b0;
      crc_ok    <= 1'b0;
      frame_cnt <= {CNT_WIDTH{1'b0}};
      err_cnt   <= {CNT_WIDTH{1'b0}};
    end else begin
      crc_done <= frame_end_s;
      crc_ok   <= frame_end_s && !frame_bad_s;
      if (frame_end_s && (frame_cnt != CNT_MAX)) begin
        frame_cnt <= frame_cnt + CNT_ONE;
      end
      if (frame_bad_s && (err_cnt != CNT_MAX)) begin
        err_cnt <= err_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_axis_crc32_mpeg2_check.sv
// Self-checking bench for axis_crc32_mpeg2_check with a bit-serial CRC model
// and queue-based scoreboard of expected output beats and frame verdicts.
module tb_axis_crc32_mpeg2_check;
  import axis_crc32_mpeg2_pkg_prm::*;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_axis_tdata = 32'h0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic        crc_done;
  logic        crc_ok;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  axis_crc32_mpeg2_check dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .crc_done      (crc_done),
    .crc_ok        (crc_ok),
    .frame_cnt     (frame_cnt),
    .err_cnt       (err_cnt)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  beat_t       exp_q[$];
  bit          stat_q[$];
  int          acc_cyc[$];
  int          m_frames = 0;
  int          m_errs = 0;
  bit          saw_stall = 1'b0;
  bit          rand_ready_en = 1'b0;
  beat_t       mon_e;
  logic [31:0] p[$];
  logic [31:0] c;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference CRC: plain polynomial division, one message bit at a time.
  function automatic logic [31:0] model_crc(input logic [31:0] q[$]);
    logic [31:0] r;
    logic        fb;
    r = INIT_CRC;
    foreach (q[i]) begin
      for (int b = 31; b >= 0; b--) begin
        fb = r[31] ^ q[i][b];
        r  = r << 1;
        if (fb) r = r ^ POLY_CRC;
      end
    end
    return r;
  endfunction

  always @(posedge aclk) cyc++;

  // Randomly toggle downstream ready when enabled.
  always @(posedge aclk) begin
    #1;
    if (rand_ready_en) m_axis_tready = ($urandom_range(0, 3) != 0);
  end

  // Scoreboard: compare every output transfer and status pulse.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (s_axis_tvalid && !s_axis_tready) saw_stall = 1'b1;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", 64'(m_axis_tdata), 64'(mon_e.data));
          check("out_last", 64'(m_axis_tlast), 64'(mon_e.last));
        end
      end
      if (crc_done) begin
        if (stat_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
        else check("crc_ok", 64'(crc_ok), 64'(stat_q.pop_front()));
      end else begin
        check("ok_without_done", 64'(crc_ok), 64'd0);
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic l);
    int n;
    @(negedge aclk);
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    n = 0;
    while (!s_axis_tready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 200) check("accept_timeout", 64'd1, 64'd0);
    else acc_cyc.push_back(cyc);
  endtask

  task automatic send_frame(input logic [31:0] q[$], input logic [31:0] cw, input bit gaps);
    logic [31:0] mc;
    mc = model_crc(q);
    foreach (q[i]) exp_q.push_back('{q[i], (i == q.size() - 1)});
    stat_q.push_back(mc == cw);
    m_frames++;
    if (mc != cw) m_errs++;
    foreach (q[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
      end
      send_beat(q[i], 1'b0);
    end
    send_beat(cw, 1'b1);
  endtask

  task automatic go_idle();
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain_and_check(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || stat_q.size() != 0) && n < 200) begin
      @(negedge aclk);
      n++;
    end
    repeat (2) @(negedge aclk);
    check({tag, "_drained"}, 64'(exp_q.size() + stat_q.size()), 64'd0);
    check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(m_frames));
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'(m_errs));
  endtask

  task automatic rand_payload(input int n);
    p.delete();
    for (int i = 0; i < n; i++) p.push_back($urandom());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_crc_done", 64'(crc_done), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_s_tready", 64'(s_axis_tready), 64'd1);

    // Directed two-word frame, good then corrupted CRC.
    p.delete();
    p.push_back(32'h1234_5678);
    p.push_back(32'hDEAD_BEEF);
    c = model_crc(p);
    send_frame(p, c, 1'b0);
    go_idle();
    drain_and_check("good2");
    send_frame(p, c ^ 32'h0000_0001, 1'b0);
    go_idle();
    drain_and_check("bad2");

    // Empty frames: all-ones passes, zero fails.
    p.delete();
    send_frame(p, 32'hFFFF_FFFF, 1'b0);
    go_idle();
    send_frame(p, 32'h0000_0000, 1'b0);
    go_idle();
    drain_and_check("empty");

    // 8-word frame with downstream stalled for 5 cycles mid-frame.
    rand_payload(8);
    saw_stall = 1'b0;
    fork
      begin
        send_frame(p, model_crc(p), 1'b0);
        go_idle();
      end
      begin
        repeat (4) @(posedge aclk);
        #1 m_axis_tready = 1'b0;
        repeat (5) @(posedge aclk);
        #1 m_axis_tready = 1'b1;
      end
    join
    check("stall_tready_dropped", 64'(saw_stall), 64'd1);
    drain_and_check("stall");

    // Three back-to-back frames, one beat per cycle (4+3+5 payload, 3 CRC).
    acc_cyc.delete();
    rand_payload(4);
    send_frame(p, model_crc(p), 1'b0);
    rand_payload(3);
    send_frame(p, model_crc(p), 1'b0);
    rand_payload(5);
    send_frame(p, model_crc(p), 1'b0);
    go_idle();
    check("b2b_beats", 64'(acc_cyc.size()), 64'd15);
    if (acc_cyc.size() == 15) check("b2b_cycles", 64'(acc_cyc[14] - acc_cyc[0]), 64'd14);
    drain_and_check("b2b");

    // Random frames with random gaps, random back-pressure and corruption.
    rand_ready_en = 1'b1;
    for (int f = 0; f < 12; f++) begin
      rand_payload($urandom_range(0, 6));
      c = model_crc(p);
      if ($urandom_range(0, 2) == 0) c = c ^ (32'h1 << $urandom_range(0, 31));
      send_frame(p, c, 1'b1);
    end
    go_idle();
    rand_ready_en = 1'b0;
    @(posedge aclk);
    #1 m_axis_tready = 1'b1;
    drain_and_check("random");

    // Abort mid-frame: only the first word has left the block when reset
    // hits; the word in the output register and the held word are dropped.
    rand_payload(3);
    exp_q.push_back('{p[0], 1'b0});
    send_beat(p[0], 1'b0);
    send_beat(p[1], 1'b0);
    send_beat(p[2], 1'b0);
    @(posedge aclk);
    #1;
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn  = 1'b1;
    m_frames = 0;
    m_errs   = 0;
    check("abort_exp_empty", 64'(exp_q.size()), 64'd0);
    check("abort_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("abort_frame_cnt", 64'(frame_cnt), 64'd0);
    check("abort_crc_done", 64'(crc_done), 64'd0);
    rand_payload(4);
    send_frame(p, model_crc(p), 1'b0);
    go_idle();
    drain_and_check("after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
